// File: rtl/atom_bridge_pkg.sv
// rtl/atom_bridge_pkg.sv - shared constants and helpers for the Atom peripheral bridge
package atom_bridge_pkg;

    localparam int OVF_BIT        = 7;
    localparam int DEF_AW         = 5;
    localparam int DEF_ADDR_W     = 3;
    localparam int DEF_NUM_CH     = 2;
    localparam bit DEF_LATCH_RD   = 1'b0;

    // Width of the channel-select field above the per-window register address.
    function automatic int ch_w(input int aw, input int addr_w);
        return aw - addr_w;
    endfunction

endpackage

// File: rtl/atom_periph_bridge_if.sv
// rtl/atom_periph_bridge_if.sv - Atom expansion bus signals seen by the bridge
interface atom_periph_bridge_if #(
    parameter int AW = 5
);
    logic [AW-1:0] Atom_Addr;
    logic          Atom_RnWR;
    logic          Atom_nB400;
    logic [7:0]    Atom_Data_In;
    logic [7:0]    Atom_Data_Out;
    logic          Atom_Data_OE;

    modport master (
        output Atom_Addr, Atom_RnWR, Atom_nB400, Atom_Data_In,
        input  Atom_Data_Out, Atom_Data_OE
    );

    modport slave (
        input  Atom_Addr, Atom_RnWR, Atom_nB400, Atom_Data_In,
        output Atom_Data_Out, Atom_Data_OE
    );
endinterface

// File: rtl/atom_ack_sync.sv
// rtl/atom_ack_sync.sv - two-flop synchroniser plus edge flop for a device acknowledge
module atom_ack_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ack_i,
    output logic rise_o
);
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    assign sync_d = {sync_q[1:0], ack_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/atom_periph_bridge.sv
// rtl/atom_periph_bridge.sv - splits the nB400 block into peripheral windows plus a status slot
module atom_periph_bridge
    import atom_bridge_pkg::*;
#(
    parameter int AW            = DEF_AW,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter bit LATCH_ON_READ = DEF_LATCH_RD
) (
    input  logic                     Atom_Phi2,
    input  logic                     Atom_nRST,
    atom_periph_bridge_if.slave      bus,
    output logic [NUM_CH*ADDR_W-1:0] Dev_Addr,
    output logic [7:0]               Dev_WData,
    output logic [NUM_CH-1:0]        Dev_nEn,
    output logic [NUM_CH-1:0]        Dev_nRD,
    output logic [NUM_CH-1:0]        Dev_nWR,
    input  logic [NUM_CH-1:0]        Dev_Ack,
    output logic                     Irq_Pend
);
    localparam int CH_W = ch_w(AW, ADDR_W);

    logic [CH_W-1:0]          sel;
    logic                     hit;
    logic [NUM_CH-1:0]        ch_sel, ch_wr, ch_rd, ack_rise;
    logic                     status_sel, status_wr;
    logic [NUM_CH*ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic [NUM_CH-1:0]        pending_q, pending_d;
    logic                     ovf_q, ovf_d;
    logic                     irq_q;
    logic [7:0]               status;

    assign sel        = bus.Atom_Addr[AW-1:ADDR_W];
    assign hit        = !bus.Atom_nB400;
    assign status_sel = hit && (sel == CH_W'(NUM_CH));
    assign status_wr  = status_sel && !bus.Atom_RnWR;

    always_comb begin
        ch_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel[c] = hit && (sel == CH_W'(c));
        end
    end

    assign ch_wr   = ch_sel & {NUM_CH{!bus.Atom_RnWR}};
    assign ch_rd   = ch_sel & {NUM_CH{bus.Atom_RnWR}};
    assign Dev_nEn = ~(ch_sel & {NUM_CH{Atom_Phi2}});
    assign Dev_nRD = ~(ch_rd & {NUM_CH{Atom_Phi2}});
    assign Dev_nWR = ~(ch_wr & {NUM_CH{Atom_Phi2}});

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ack
        atom_ack_sync u_sync (
            .clk_i   (Atom_Phi2),
            .rst_n_i (Atom_nRST),
            .ack_i   (Dev_Ack[g]),
            .rise_o  (ack_rise[g])
        );
    end

    // A new write outranks a same-edge ack; only then is a stale pending an overflow.
    always_comb begin
        addr_d    = addr_q;
        pending_d = pending_q;
        wdata_d   = (|ch_wr) ? bus.Atom_Data_In : wdata_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_wr[c] || (LATCH_ON_READ && ch_rd[c])) begin
                addr_d[c*ADDR_W +: ADDR_W] = bus.Atom_Addr[ADDR_W-1:0];
            end
            if (ch_wr[c]) begin
                pending_d[c] = 1'b1;
            end else if (ack_rise[c]) begin
                pending_d[c] = 1'b0;
            end else if (status_wr && bus.Atom_Data_In[c]) begin
                pending_d[c] = 1'b0;
            end
        end
        if (|(ch_wr & pending_q & ~ack_rise)) begin
            ovf_d = 1'b1;
        end else if (status_wr && bus.Atom_Data_In[OVF_BIT]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge Atom_Phi2 or negedge Atom_nRST) begin
        if (!Atom_nRST) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            irq_q     <= |pending_d;
        end
    end

    always_comb begin
        status                 = '0;
        status[NUM_CH-1:0]     = pending_q;
        status[OVF_BIT]        = ovf_q;
    end

    assign bus.Atom_Data_OE  = status_sel && bus.Atom_RnWR && Atom_Phi2;
    assign bus.Atom_Data_Out = bus.Atom_Data_OE ? status : 8'h00;
    assign Dev_Addr          = addr_q;
    assign Dev_WData         = wdata_q;
    assign Irq_Pend          = irq_q;
endmodule

// File: tb/tb_atom_periph_bridge.sv
// tb/tb_atom_periph_bridge.sv - directed scoreboard bench for atom_periph_bridge
module tb_atom_periph_bridge;
    logic       phi2 = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] addr = 5'b00101;
    logic       rnw = 1'b0;
    logic       nb400 = 1'b0;
    logic [7:0] din = 8'h00;
    logic [1:0] ack = 2'b00;

    logic [5:0] dev_addr0, dev_addr1;
    logic [7:0] wdata0, wdata1;
    logic [1:0] nen0, nrd0, nwr0, nen1, nrd1, nwr1;
    logic       irq0, irq1;

    int checks = 0;
    int failures = 0;
    logic [7:0] sb_q[$];

    always #10 phi2 = ~phi2;

    atom_periph_bridge_if #(.AW(5)) bus0 ();
    atom_periph_bridge_if #(.AW(5)) bus1 ();

    assign bus0.Atom_Addr    = addr;
    assign bus0.Atom_RnWR    = rnw;
    assign bus0.Atom_nB400   = nb400;
    assign bus0.Atom_Data_In = din;
    assign bus1.Atom_Addr    = addr;
    assign bus1.Atom_RnWR    = rnw;
    assign bus1.Atom_nB400   = nb400;
    assign bus1.Atom_Data_In = din;

    atom_periph_bridge #(.AW(5), .ADDR_W(3), .NUM_CH(2), .LATCH_ON_READ(1'b0)) dut0 (
        .Atom_Phi2(phi2), .Atom_nRST(rst_n), .bus(bus0.slave),
        .Dev_Addr(dev_addr0), .Dev_WData(wdata0), .Dev_nEn(nen0), .Dev_nRD(nrd0),
        .Dev_nWR(nwr0), .Dev_Ack(ack), .Irq_Pend(irq0)
    );

    atom_periph_bridge #(.AW(5), .ADDR_W(3), .NUM_CH(2), .LATCH_ON_READ(1'b1)) dut1 (
        .Atom_Phi2(phi2), .Atom_nRST(rst_n), .bus(bus1.slave),
        .Dev_Addr(dev_addr1), .Dev_WData(wdata1), .Dev_nEn(nen1), .Dev_nRD(nrd1),
        .Dev_nWR(nwr1), .Dev_Ack(ack), .Irq_Pend(irq1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle during Phi2 low; returns 5 time units into Phi2 high.
    task automatic bus_op(input logic [4:0] a, input logic r, input logic [7:0] d);
        @(negedge phi2);
        addr = a; rnw = r; din = d; nb400 = 1'b0;
        @(posedge phi2);
        #5;
    endtask

    task automatic idle_edge(input logic [1:0] ack_val);
        @(negedge phi2);
        nb400 = 1'b1; rnw = 1'b1; ack = ack_val;
        @(posedge phi2);
        #1;
    endtask

    task automatic status_read(input string tag, input logic [7:0] exp);
        logic [7:0] want;
        sb_q.push_back(exp);
        bus_op(5'b10000, 1'b1, 8'h00);
        check({tag, "_oe0"}, bus0.Atom_Data_OE, 1'b1);
        check({tag, "_oe1"}, bus1.Atom_Data_OE, 1'b1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            want = sb_q.pop_front();
            check({tag, "_dout0"}, bus0.Atom_Data_Out, want);
            check({tag, "_dout1"}, bus1.Atom_Data_Out, want);
        end
    endtask

    initial begin
        // Reset asserted in the middle of Phi2 high, with a channel-0 write on the bus.
        @(posedge phi2);
        #5 rst_n = 1'b0;
        #1;
        check("rst_addr0", dev_addr0, 6'd0);
        check("rst_addr1", dev_addr1, 6'd0);
        check("rst_wdata", wdata0, 8'h00);
        check("rst_irq", irq0, 1'b0);
        @(negedge phi2);
        #1;
        check("rst_nen_low_phase", nen0, 2'b11);
        check("rst_nwr_low_phase", nwr0, 2'b11);
        nb400 = 1'b1; rnw = 1'b1;
        @(negedge phi2);
        @(negedge phi2);
        rst_n = 1'b1;
        status_read("rst_status", 8'h00);

        // Write 0x5A to channel 0 register 5.
        @(negedge phi2);
        addr = 5'b00101; rnw = 1'b0; din = 8'h5A; nb400 = 1'b0;
        #1;
        check("wr0_nwr_phi2_low", nwr0, 2'b11);
        @(posedge phi2);
        #5;
        check("wr0_nwr_phi2_high", nwr0, 2'b10);
        check("wr0_nen", nen0, 2'b10);
        check("wr0_nrd", nrd0, 2'b11);
        check("wr0_addr", dev_addr0, 6'b000_101);
        check("wr0_wdata", wdata0, 8'h5A);
        check("wr0_irq", irq0, 1'b1);
        status_read("wr0_status", 8'h01);

        // Ack pulse on channel 0 clears pending on the third Phi2 rise.
        idle_edge(2'b01);
        check("ack_e1_irq", irq0, 1'b1);
        idle_edge(2'b00);
        check("ack_e2_irq", irq0, 1'b1);
        idle_edge(2'b00);
        check("ack_e3_irq", irq0, 1'b0);
        status_read("ack_status", 8'h00);

        // Back-to-back channel-1 writes without ack set overflow.
        bus_op(5'b01010, 1'b0, 8'h11);
        bus_op(5'b01010, 1'b0, 8'h22);
        check("ch1_wdata", wdata0, 8'h22);
        check("ch1_addr_ch0_held", dev_addr0, 6'b010_101);
        status_read("ovf_status", 8'h82);
        bus_op(5'b10000, 1'b0, 8'h80);
        status_read("ovf_clr_status", 8'h02);
        check("stat_wr_no_wdata", wdata0, 8'h22);
        bus_op(5'b10000, 1'b0, 8'h02);
        status_read("abort_status", 8'h00);
        check("abort_irq", irq0, 1'b0);

        // Write to channel 0 landing on the same edge as its ack rise.
        bus_op(5'b00001, 1'b0, 8'h33);
        idle_edge(2'b01);
        idle_edge(2'b00);
        bus_op(5'b00001, 1'b0, 8'h44);
        check("same_edge_irq", irq0, 1'b1);
        status_read("same_edge_status", 8'h01);
        bus_op(5'b10000, 1'b0, 8'h01);
        status_read("same_edge_abort", 8'h00);

        // Channel-1 read: address latched only with LATCH_ON_READ.
        bus_op(5'b01011, 1'b1, 8'h00);
        check("rd1_nrd0", nrd0, 2'b01);
        check("rd1_nrd1", nrd1, 2'b01);
        check("rd1_nwr0", nwr0, 2'b11);
        check("rd1_nen0", nen0, 2'b01);
        check("rd1_oe", bus0.Atom_Data_OE, 1'b0);
        check("rd1_dout", bus0.Atom_Data_Out, 8'h00);
        check("rd1_addr_nolatch", dev_addr0, 6'b010_001);
        check("rd1_addr_latch", dev_addr1, 6'b011_001);

        // Select beyond the status slot is ignored.
        bus_op(5'b11000, 1'b0, 8'hFF);
        check("beyond_wr_nen", nen0, 2'b11);
        check("beyond_wr_nwr", nwr0, 2'b11);
        check("beyond_wr_wdata", wdata0, 8'h44);
        bus_op(5'b11000, 1'b1, 8'h00);
        check("beyond_rd_oe", bus0.Atom_Data_OE, 1'b0);
        check("beyond_rd_dout", bus0.Atom_Data_Out, 8'h00);
        status_read("beyond_status", 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
